uart_tx_core: RTL

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_core_if.sv | 25 ++
 rtl/uart_tx_core_serializer.sv | 40 ++++
 rtl/uart_tx_core.sv | 104 ++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit core.
package uart_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // data_xor is the reduction XOR of the payload; odd parity inverts it.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Parallel-side request bus and serial-side outputs of the UART transmitter.
interface uart_tx_core_if
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );

endinterface

// File: rtl/uart_tx_core_serializer.sv
// Payload shift register and bit-index counter for the UART transmitter.
module uart_tx_core_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  uart_tx_core_CLK,
  input  logic                  uart_tx_core_RST_ASYN,
  input  logic                  load,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_out,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_WIDTH-1:0]  bit_idx;

  always_ff @(posedge uart_tx_core_CLK or posedge uart_tx_core_RST_ASYN) begin
    if (uart_tx_core_RST_ASYN) begin
      shift_q <= '0;
      bit_idx <= '0;
    end else if (load) begin
      shift_q <= data_in;
      bit_idx <= '0;
    end else if (enable) begin
      shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
      if (bit_idx != '1) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end else begin
      bit_idx <= '0;
    end
  end

  // ser_out is the bit the core registers at the coming edge: bit 0 when
  // entering DATA, the following bit while shifting.
  assign ser_out = enable ? shift_q[1] : shift_q[0];
  assign done    = enable && (bit_idx == '1);

endmodule

// File: rtl/uart_tx_core.sv
// UART frame sequencer: start, LSB-first data, optional parity, stop.
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 3
) (
  input  logic           uart_tx_core_CLK,
  input  logic           uart_tx_core_RST_ASYN,
  uart_tx_core_if.slave  bus
);

  tx_state_t state;
  logic      tx_q;
  logic      busy_q;
  logic      par_en_q;
  logic      par_bit_q;
  logic      accept;
  logic      ser_en;
  logic      ser_bit;
  logic      ser_done;

  // Requests are only taken when the line is free or finishing a stop bit.
  assign accept = bus.Data_Valid && ((state == ST_IDLE) || (state == ST_STOP));
  assign ser_en = (state == ST_DATA);

  uart_tx_core_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_serializer (
    .uart_tx_core_CLK      (uart_tx_core_CLK),
    .uart_tx_core_RST_ASYN (uart_tx_core_RST_ASYN),
    .load                  (accept),
    .enable                (ser_en),
    .data_in               (bus.P_DATA),
    .ser_out               (ser_bit),
    .done                  (ser_done)
  );

  always_ff @(posedge uart_tx_core_CLK or posedge uart_tx_core_RST_ASYN) begin
    if (uart_tx_core_RST_ASYN) begin
      state     <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      if (accept) begin
        par_en_q  <= bus.PAR_EN;
        par_bit_q <= parity_bit(^bus.P_DATA, bus.PAR_TYP);
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_START;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        ST_START: begin
          state <= ST_DATA;
          tx_q  <= ser_bit;
        end
        ST_DATA: begin
          if (!ser_done) begin
            tx_q <= ser_bit;
          end else if (par_en_q) begin
            state <= ST_PARITY;
            tx_q  <= par_bit_q;
          end else begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
        end
        ST_PARITY: begin
          state <= ST_STOP;
          tx_q  <= 1'b1;
        end
        ST_STOP: begin
          if (accept) begin
            state <= ST_START;
            tx_q  <= 1'b0;
          end else begin
            state  <= ST_IDLE;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule
